uart_i2c_cmd_sequencer: RTL

Sits between the UART receiver/transmitter byte interfaces and the I2C master engine in the uart-to-I2C bridge. Assembles fixed 4-byte UART command frames into one I2C register transaction: {dev_addr[6:0],rw}, reg_addr, data_hi, data_lo. Launches the transaction, waits for completion and returns a status or read-data response over UART TX. Serialises all traffic, so only one I2C transaction is ever outstanding.

---
 rtl/uart_i2c_cmd_sequencer_if.sv | 41 ++++
 rtl/uart_i2c_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_i2c_cmd_sequencer_if.sv
// Bundle of UART byte and I2C command/response signals for the command sequencer.
//   master : sequencer side (drives tx_*, i2c command outputs, frame_err, busy)
//   slave  : environment side (UART RX/TX and I2C master engine)
// Signals:
//   rx_data/rx_valid       byte strobe from UART RX
//   tx_data/tx_valid/ready byte handshake to UART TX
//   i2c_start/dev_addr/rw/reg_addr/wdata  transaction launch
//   i2c_busy/done/ack_err/rdata           transaction completion
//   i2c_abort              watchdog abort pulse (0 unless UART_I2C_WDT_EN)
//   frame_err, busy        status
interface uart_i2c_cmd_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        i2c_start;
  logic [6:0]  i2c_dev_addr;
  logic        i2c_rw;
  logic [7:0]  i2c_reg_addr;
  logic [15:0] i2c_wdata;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_ack_err;
  logic [15:0] i2c_rdata;
  logic        i2c_abort;
  logic        frame_err;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, i2c_busy, i2c_done, i2c_ack_err, i2c_rdata,
    output tx_data, tx_valid, i2c_start, i2c_dev_addr, i2c_rw, i2c_reg_addr,
           i2c_wdata, i2c_abort, frame_err, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, i2c_busy, i2c_done, i2c_ack_err, i2c_rdata,
    input  tx_data, tx_valid, i2c_start, i2c_dev_addr, i2c_rw, i2c_reg_addr,
           i2c_wdata, i2c_abort, frame_err, busy
  );
endinterface

// File: rtl/uart_i2c_cmd_sequencer.sv
// UART-to-I2C command sequencer. Collects 4-byte frames
// {dev_addr,rw}, reg_addr, data_hi, data_lo, launches one I2C register
// transaction, waits for completion and returns status or read data on UART TX.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  uart_i2c_cmd_sequencer_if.master (UART bytes, I2C command/response, status)
// Optional build macro UART_I2C_WDT_EN adds an I2C completion watchdog
// (WDT_ABORT state, i2c_abort pulse, STATUS_TMO response).
//
// state       | meaning
// ------------+---------------------------------------------------
// S_IDLE      | waiting for first frame byte
// S_COLLECT   | gathering bytes 1..3, gap timer running
// S_ISSUE     | frame complete, waiting for I2C master not busy
// S_WAIT_I2C  | transaction outstanding, waiting for i2c_done
// S_RESP      | sending 1 or 2 response bytes on UART TX
// S_WDT_ABORT | watchdog fired, preparing STATUS_TMO (WDT build only)
module uart_i2c_cmd_sequencer #(
  parameter int unsigned BYTE_TIMEOUT_CYC = 100000,
  parameter int unsigned WDT_CYC          = 2000000,
  parameter logic [7:0]  STATUS_OK        = 8'h00,
  parameter logic [7:0]  STATUS_NACK      = 8'hEE,
  parameter logic [7:0]  STATUS_TMO       = 8'hE0
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_i2c_cmd_sequencer_if.master      bus
);

  localparam int unsigned GAP_W = $clog2(BYTE_TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(BYTE_TIMEOUT_CYC);

  // Elaboration-time sanity checks on the configuration.
  if (BYTE_TIMEOUT_CYC == 0 || WDT_CYC == 0) begin : g_bad_timer
    $error("timer limits must be non-zero");
  end
  if (STATUS_TMO == STATUS_OK || STATUS_NACK == STATUS_OK) begin : g_bad_status
    $error("error status codes must differ from STATUS_OK");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_ISSUE, S_WAIT_I2C, S_RESP
`ifdef UART_I2C_WDT_EN
    , S_WDT_ABORT
`endif
  } state_t;

  state_t           state_q;
  logic [1:0]       byte_cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic [6:0]       dev_addr_q;
  logic             rw_q;
  logic [7:0]       reg_addr_q;
  logic [15:0]      wdata_q;
  logic             ack_err_q;
  logic [15:0]      rdata_q;
  logic             resp_idx_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             start_q;
  logic             frame_err_q;
  logic [7:0]       resp_byte;
  logic             resp_last;

`ifdef UART_I2C_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYC + 1);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYC);
  logic [WDT_W-1:0] wdt_q;
  logic             tmo_q;
  logic             abort_q;
  assign bus.i2c_abort = abort_q;
`else
  assign bus.i2c_abort = 1'b0;
`endif

  // Response byte selected by the latched completion status and byte index.
  always_comb begin
    resp_byte = STATUS_OK;
    resp_last = 1'b1;
`ifdef UART_I2C_WDT_EN
    if (tmo_q) resp_byte = STATUS_TMO;
    else
`endif
    if (ack_err_q) begin
      resp_byte = STATUS_NACK;
    end else if (rw_q) begin
      resp_byte = resp_idx_q ? rdata_q[7:0] : rdata_q[15:8];
      resp_last = resp_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      gap_q       <= '0;
      dev_addr_q  <= '0;
      rw_q        <= 1'b0;
      reg_addr_q  <= '0;
      wdata_q     <= '0;
      ack_err_q   <= 1'b0;
      rdata_q     <= '0;
      resp_idx_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      start_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_I2C_WDT_EN
      wdt_q       <= '0;
      tmo_q       <= 1'b0;
      abort_q     <= 1'b0;
`endif
    end else begin
      start_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_I2C_WDT_EN
      abort_q     <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.rx_valid) begin
            {dev_addr_q, rw_q} <= bus.rx_data;
            byte_cnt_q <= 2'd1;
            gap_q      <= '0;
            state_q    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          // A byte arriving in the timeout cycle still counts.
          if (bus.rx_valid) begin
            case (byte_cnt_q)
              2'd1:    reg_addr_q     <= bus.rx_data;
              2'd2:    wdata_q[15:8]  <= bus.rx_data;
              default: wdata_q[7:0]   <= bus.rx_data;
            endcase
            byte_cnt_q <= byte_cnt_q + 2'd1;
            gap_q      <= '0;
            if (byte_cnt_q == 2'd3) begin
              state_q <= S_ISSUE;
`ifdef UART_I2C_WDT_EN
              wdt_q   <= '0;
`endif
            end
          end else if (gap_q == GAP_MAX) begin
            frame_err_q <= 1'b1;
            byte_cnt_q  <= '0;
            state_q     <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_ISSUE: begin
          if (!bus.i2c_busy) begin
            start_q <= 1'b1;
            state_q <= S_WAIT_I2C;
`ifdef UART_I2C_WDT_EN
            wdt_q   <= '0;
          end else if (wdt_q == WDT_MAX) begin
            abort_q <= 1'b1;
            state_q <= S_WDT_ABORT;
          end else begin
            wdt_q <= wdt_q + 1'b1;
`endif
          end
        end
        S_WAIT_I2C: begin
          // i2c_done takes priority over a coincident watchdog expiry.
          if (bus.i2c_done) begin
            ack_err_q  <= bus.i2c_ack_err;
            rdata_q    <= bus.i2c_rdata;
            resp_idx_q <= 1'b0;
            state_q    <= S_RESP;
`ifdef UART_I2C_WDT_EN
          end else if (wdt_q == WDT_MAX) begin
            abort_q <= 1'b1;
            state_q <= S_WDT_ABORT;
          end else begin
            wdt_q <= wdt_q + 1'b1;
`endif
          end
        end
`ifdef UART_I2C_WDT_EN
        S_WDT_ABORT: begin
          tmo_q      <= 1'b1;
          resp_idx_q <= 1'b0;
          state_q    <= S_RESP;
        end
`endif
        S_RESP: begin
          // Present only when idle, so there is always a one-cycle gap between bytes.
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= resp_byte;
          end else if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            if (resp_last) begin
              resp_idx_q <= 1'b0;
              state_q    <= S_IDLE;
`ifdef UART_I2C_WDT_EN
              tmo_q      <= 1'b0;
`endif
            end else begin
              resp_idx_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Bytes arriving while a transaction is in flight are dropped.
      if (bus.rx_valid && state_q != S_IDLE && state_q != S_COLLECT)
        frame_err_q <= 1'b1;
    end
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.i2c_start    = start_q;
  assign bus.i2c_dev_addr = dev_addr_q;
  assign bus.i2c_rw       = rw_q;
  assign bus.i2c_reg_addr = reg_addr_q;
  assign bus.i2c_wdata    = wdata_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule
